// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the ALU pipeline.
// Drives the I-cache with the fetch PC and predicts the next PC using a
// 2-bit-counter BHT with a direct-mapped BTB. It fills the IF/ID register,
// applies the stall and flush priorities, and trains the predictor from
// EX-stage branch resolution.
module instruction_fetch #(
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_stall,
    input  logic        icache_stall,
    input  logic        PC_write,
    input  logic [31:0] IF_DWrite,
    input  logic        flush,
    input  logic [31:0] redirect_PC,
    input  logic        branch_resolve,
    input  logic        actual_taken,
    input  logic [31:0] branch_PC_3,
    input  logic [31:0] branch_target_3,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] instruction_1,
    output logic [31:0] PC_1,
    output logic        prev_taken_1
);

    localparam int          IDX  = $clog2(BHT_ENTRIES);
    localparam int          TAGW = 30 - IDX;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0]     pc_r;
    logic [1:0]      cnt    [BHT_ENTRIES];
    logic            valid  [BHT_ENTRIES];
    logic [TAGW-1:0] tag    [BHT_ENTRIES];
    logic [31:0]     target [BHT_ENTRIES];

    logic [IDX-1:0]  l_idx;
    logic            l_hit;
    logic            pred_taken;
    logic [31:0]     next_pc;

    logic [IDX-1:0]  t_idx;
    logic [TAGW-1:0] t_tag;
    logic            t_hit;
    logic [1:0]      t_cnt;

    // The two low PC bits are always zero for word-aligned branches.
    logic unused_ok;
    assign unused_ok = ^branch_PC_3[1:0];

    assign ICACHE_ren  = !rst;
    assign ICACHE_addr = pc_r[31:2];

    // Predictor lookup on the current fetch PC and next-PC selection.
    always_comb begin
        l_idx      = pc_r[IDX+1:2];
        l_hit      = valid[l_idx] && (tag[l_idx] == pc_r[31:IDX+2]);
        pred_taken = l_hit && cnt[l_idx][1];
        next_pc    = pred_taken ? target[l_idx] : pc_r + 32'd4;
    end

    // Counter update value for the entry addressed by the resolving branch.
    always_comb begin
        t_idx = branch_PC_3[IDX+1:2];
        t_tag = branch_PC_3[31:IDX+2];
        t_hit = valid[t_idx] && (tag[t_idx] == t_tag);
        if (actual_taken) begin
            if (!t_hit)                   t_cnt = 2'b10;
            else if (cnt[t_idx] == 2'b11) t_cnt = 2'b11;
            else                          t_cnt = cnt[t_idx] + 2'd1;
        end else begin
            if (cnt[t_idx] == 2'b00)      t_cnt = 2'b00;
            else                          t_cnt = cnt[t_idx] - 2'd1;
        end
    end

    // Fetch PC and IF/ID register with reset > memory stall > flush > hazard > icache stall priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            instruction_1 <= NOP;
            PC_1          <= '0;
            prev_taken_1  <= 1'b0;
        end else if (memory_stall) begin
            pc_r <= pc_r;
        end else if (flush) begin
            pc_r          <= redirect_PC;
            instruction_1 <= NOP;
            PC_1          <= '0;
            prev_taken_1  <= 1'b0;
        end else if (PC_write) begin
            instruction_1 <= IF_DWrite;
        end else if (icache_stall) begin
            instruction_1 <= NOP;
            PC_1          <= '0;
            prev_taken_1  <= 1'b0;
        end else begin
            instruction_1 <= ICACHE_rdata;
            PC_1          <= pc_r;
            prev_taken_1  <= pred_taken;
            pc_r          <= next_pc;
        end
    end

    // Predictor training from EX resolution; lookup this cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                cnt[i]    <= 2'b01;
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
            end
        end else if (!memory_stall && branch_resolve) begin
            if (actual_taken) begin
                cnt[t_idx]    <= t_cnt;
                valid[t_idx]  <= 1'b1;
                tag[t_idx]    <= t_tag;
                target[t_idx] <= branch_target_3;
            end else if (t_hit) begin
                cnt[t_idx] <= t_cnt;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, a few hand sequences and a
// randomized phase checked against a behavioural predictor/fetch model.
module tb_instruction_fetch;

    localparam int          BHT  = 16;
    localparam int          IDX  = $clog2(BHT);
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] DW   = 32'h0020_8133;
    localparam int          IK_MEM = 0;
    localparam int          IK_NOP = 1;
    localparam int          IK_DW  = 2;

    logic        clk = 1'b0;
    logic        rst, memory_stall, icache_stall, PC_write, flush;
    logic        branch_resolve, actual_taken;
    logic [31:0] IF_DWrite, redirect_PC, branch_PC_3, branch_target_3;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] instruction_1, PC_1;
    logic        prev_taken_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hA500_0000;
    endfunction

    assign ICACHE_rdata = mem_word(ICACHE_addr);

    instruction_fetch #(.BHT_ENTRIES(BHT), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .memory_stall(memory_stall), .icache_stall(icache_stall),
        .PC_write(PC_write), .IF_DWrite(IF_DWrite), .flush(flush), .redirect_PC(redirect_PC),
        .branch_resolve(branch_resolve), .actual_taken(actual_taken),
        .branch_PC_3(branch_PC_3), .branch_target_3(branch_target_3),
        .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr), .ICACHE_rdata(ICACHE_rdata),
        .instruction_1(instruction_1), .PC_1(PC_1), .prev_taken_1(prev_taken_1)
    );

    typedef struct {
        logic        rst, ms, ics, pw, fl, br, at;
        logic [31:0] rpc, bpc, btg;
        logic [31:0] epcr, epc1;
        logic        etk;
        int          ik;
    } vec_t;

    function automatic vec_t mk(input logic r, ms, ics, pw, fl, br, at,
                                input logic [31:0] rpc, bpc, btg, epcr, epc1,
                                input logic etk, input int ik);
        vec_t v;
        v.rst = r; v.ms = ms; v.ics = ics; v.pw = pw; v.fl = fl; v.br = br; v.at = at;
        v.rpc = rpc; v.bpc = bpc; v.btg = btg; v.epcr = epcr; v.epc1 = epc1;
        v.etk = etk; v.ik = ik;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst; memory_stall = v.ms; icache_stall = v.ics; PC_write = v.pw;
        flush = v.fl; redirect_PC = v.rpc; branch_resolve = v.br; actual_taken = v.at;
        branch_PC_3 = v.bpc; branch_target_3 = v.btg; IF_DWrite = DW;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] einst;
        drive(v);
        einst = (v.ik == IK_NOP) ? NOP : (v.ik == IK_DW) ? DW : mem_word(v.epc1[31:2]);
        chk({tag, ".addr"}, {2'b00, ICACHE_addr}, {2'b00, v.epcr[31:2]});
        chk({tag, ".ren"},  {31'd0, ICACHE_ren}, {31'd0, !v.rst});
        chk({tag, ".pc1"},  PC_1, v.epc1);
        chk({tag, ".tk1"},  {31'd0, prev_taken_1}, {31'd0, v.etk});
        chk({tag, ".inst"}, instruction_1, einst);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_inst, m_pc1;
    logic        m_tk;
    bit          bht_v   [BHT];
    logic [31:0] bht_own [BHT];
    logic [31:0] bht_tgt [BHT];
    int unsigned bht_str [BHT];

    function automatic int unsigned slot(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(BHT - 1));
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDX + 2)) == (b >> (IDX + 2));
    endfunction

    task automatic model_step(input vec_t s);
        int unsigned li, ti;
        bit          hit, pt, same;
        logic [31:0] nxt;
        li  = slot(m_pc);
        hit = bht_v[li] && same_tag(bht_own[li], m_pc);
        pt  = hit && (bht_str[li] >= 2);
        nxt = pt ? bht_tgt[li] : m_pc + 32'd4;
        if (s.rst) begin
            m_pc = 32'h0; m_inst = NOP; m_pc1 = 32'h0; m_tk = 1'b0;
            for (int i = 0; i < BHT; i++) begin
                bht_v[i] = 0; bht_str[i] = 1; bht_own[i] = 0; bht_tgt[i] = 0;
            end
        end else if (!s.ms) begin
            if (s.fl) begin
                m_pc = s.rpc; m_inst = NOP; m_pc1 = 0; m_tk = 0;
            end else if (s.pw) begin
                m_inst = DW;
            end else if (s.ics) begin
                m_inst = NOP; m_pc1 = 0; m_tk = 0;
            end else begin
                m_inst = mem_word(m_pc[31:2]); m_pc1 = m_pc; m_tk = pt; m_pc = nxt;
            end
            if (s.br) begin
                ti   = slot(s.bpc);
                same = bht_v[ti] && same_tag(bht_own[ti], s.bpc);
                if (s.at) begin
                    bht_str[ti] = same ? ((bht_str[ti] < 3) ? bht_str[ti] + 1 : 3) : 2;
                    bht_v[ti]   = 1;
                    bht_own[ti] = s.bpc;
                    bht_tgt[ti] = s.btg;
                end else if (same) begin
                    bht_str[ti] = (bht_str[ti] > 0) ? bht_str[ti] - 1 : 0;
                end
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        rst = 1; memory_stall = 0; icache_stall = 0; PC_write = 0; flush = 0;
        redirect_PC = 0; branch_resolve = 0; actual_taken = 0;
        branch_PC_3 = 0; branch_target_3 = 0; IF_DWrite = DW;

        //                 rst ms ics pw fl br at  redirect      bpc    btg     PC_r          PC_1          tk  inst
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h0,        32'h0,        0, IK_NOP));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h0,        32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h4,        32'h0,        0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h8,        32'h4,        0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'hC,        32'h8,        0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'hC,        32'h8,        0, IK_DW));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'hC,        32'h8,        0, IK_DW));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h10,       32'hC,        0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h100,      32'h0,  32'h0,  32'h100,      32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h104,      32'h100,      0, IK_MEM));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h104,      32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h104,      32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h104,      32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h108,      32'h104,      0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h40, 32'h80, 32'h10C,      32'h108,      0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h40, 32'h80, 32'h110,      32'h10C,      0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h40,       32'h0,  32'h0,  32'h40,       32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h80,       32'h40,       1, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h84,       32'h80,       0, IK_MEM));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 32'h200,      32'h40, 32'h300,32'h84,       32'h80,       0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h40,       32'h0,  32'h0,  32'h40,       32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h80,       32'h40,       1, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h40, 32'h0,  32'h84,       32'h80,       0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h40, 32'h0,  32'h88,       32'h84,       0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h40,       32'h0,  32'h0,  32'h40,       32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h44,       32'h40,       0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFC, 32'h0,  32'h0,  32'hFFFFFFFC, 32'h0,        0, IK_NOP));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h0,        32'hFFFFFFFC, 0, IK_MEM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,  32'h0,  32'h4,        32'h0,        0, IK_MEM));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h200,      32'h8,  32'h300,32'h0,        32'h0,        0, IK_NOP));

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Same-cycle lookup and training of one entry: lookup uses the old contents.
        run_vec("same0", mk(0, 0, 0, 0, 1, 0, 0, 32'h140, 32'h0,   32'h0,   32'h140, 32'h0,   0, IK_NOP));
        run_vec("same1", mk(0, 0, 0, 0, 0, 1, 1, 32'h0,   32'h140, 32'h500, 32'h144, 32'h140, 0, IK_MEM));
        run_vec("same2", mk(0, 0, 0, 0, 1, 0, 0, 32'h140, 32'h0,   32'h0,   32'h140, 32'h0,   0, IK_NOP));
        run_vec("same3", mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h500, 32'h140, 1, IK_MEM));
        // A mid-run reset wipes the trained entry.
        run_vec("rclr0", mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0,   0, IK_NOP));
        run_vec("rclr1", mk(0, 0, 0, 0, 1, 0, 0, 32'h140, 32'h0,   32'h0,   32'h140, 32'h0,   0, IK_NOP));
        run_vec("rclr2", mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h144, 32'h140, 0, IK_MEM));

        // Randomized phase against the reference model.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IK_NOP);
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) begin
                v.rst = ($urandom_range(0, 99) == 0);
                v.ms  = ($urandom_range(0, 7) == 0);
                v.fl  = ($urandom_range(0, 7) == 0);
                v.pw  = ($urandom_range(0, 7) == 0);
                v.ics = ($urandom_range(0, 7) == 0);
                v.br  = ($urandom_range(0, 2) == 0);
                v.at  = ($urandom_range(0, 2) != 0);
                v.rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 127)) << 2;
                v.bpc = 32'($urandom_range(0, 127)) << 2;
                v.btg = 32'($urandom_range(0, 127)) << 2;
            end
            drive(v);
            model_step(v);
            chk("rnd.addr", {2'b00, ICACHE_addr}, {2'b00, m_pc[31:2]});
            chk("rnd.ren",  {31'd0, ICACHE_ren}, {31'd0, !v.rst});
            chk("rnd.pc1",  PC_1, m_pc1);
            chk("rnd.tk1",  {31'd0, prev_taken_1}, {31'd0, m_tk});
            chk("rnd.inst", instruction_1, m_inst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
